// File: rtl/sort_pkg.sv
// Shared types and defaults for the sorter and its downstream stages.
package sort_pkg;

    // Default value width used by the sort stages.
    localparam int unsigned SORT_WIDTH_DEFAULT = 3;

    // Frame tracker states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } tt_state_t;

endpackage : sort_pkg

// File: rtl/top3_tracker_if.sv
// Bus between the sorter side and the top-3 tracker.
//   master: drives start, the sorted input triple and out_ready; observes results/flags.
//   slave : the tracker; consumes the triple, drives top1..3, out_valid, busy, dropped.
interface top3_tracker_if #(
    parameter int unsigned WIDTH = sort_pkg::SORT_WIDTH_DEFAULT
);
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] in_hi;
    logic [WIDTH-1:0] in_mid;
    logic [WIDTH-1:0] in_lo;
    logic [WIDTH-1:0] top1;
    logic [WIDTH-1:0] top2;
    logic [WIDTH-1:0] top3;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             dropped;

    modport master (
        output start, in_valid, in_hi, in_mid, in_lo, out_ready,
        input  top1, top2, top3, out_valid, busy, dropped
    );

    modport slave (
        input  start, in_valid, in_hi, in_mid, in_lo, out_ready,
        output top1, top2, top3, out_valid, busy, dropped
    );
endinterface : top3_tracker_if

// File: rtl/top3_merge.sv
// Combinational merge of two descending-sorted triples into the top three of
// all six values, sorted descending, duplicates kept.
//   a_hi/a_mid/a_lo : first sorted triple
//   b_hi/b_mid/b_lo : second sorted triple
//   top1_c..top3_c  : three largest values, top1_c >= top2_c >= top3_c
module top3_merge #(
    parameter int unsigned WIDTH = sort_pkg::SORT_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a_hi,
    input  logic [WIDTH-1:0] a_mid,
    input  logic [WIDTH-1:0] a_lo,
    input  logic [WIDTH-1:0] b_hi,
    input  logic [WIDTH-1:0] b_mid,
    input  logic [WIDTH-1:0] b_lo,
    output logic [WIDTH-1:0] top1_c,
    output logic [WIDTH-1:0] top2_c,
    output logic [WIDTH-1:0] top3_c
);
    // Pairing a with b reversed: the pairwise maxima are exactly the top
    // three of the union, just not in order.
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;

    assign p = (a_hi  >= b_lo)  ? a_hi  : b_lo;
    assign q = (a_mid >= b_mid) ? a_mid : b_mid;
    assign r = (a_lo  >= b_hi)  ? a_lo  : b_hi;

    // Three compare-exchange stages to order p, q, r.
    logic [WIDTH-1:0] s1_hi;
    logic [WIDTH-1:0] s1_lo;
    logic [WIDTH-1:0] s2_hi;
    logic [WIDTH-1:0] s2_lo;

    assign s1_hi = (p >= q) ? p : q;
    assign s1_lo = (p >= q) ? q : p;

    assign s2_hi = (s1_lo >= r) ? s1_lo : r;
    assign s2_lo = (s1_lo >= r) ? r : s1_lo;

    assign top1_c = (s1_hi >= s2_hi) ? s1_hi : s2_hi;
    assign top2_c = (s1_hi >= s2_hi) ? s2_hi : s1_hi;
    assign top3_c = s2_lo;

endmodule : top3_merge

// File: rtl/top3_tracker.sv
// Running top-3 tracker over a frame of FRAME_LEN sorted triples; presents
// the frame result with a valid/ready handshake. Never back-pressures input.
//   clk, rst         : clock, synchronous active-high reset
//   bus.start        : opens a frame when idle
//   bus.in_valid/in_*: sorted triple from the sorter
//   bus.top1..3      : running/final top-3
//   bus.out_valid    : final result available (held until out_ready)
//   bus.busy         : frame in progress
//   bus.dropped      : sticky, a triple was discarded since the last start
module top3_tracker
    import sort_pkg::*;
#(
    parameter int unsigned WIDTH     = SORT_WIDTH_DEFAULT,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic           clk,
    input  logic           rst,
    top3_tracker_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    tt_state_t        state_q;
    tt_state_t        state_d;
    logic [WIDTH-1:0] top1_q;
    logic [WIDTH-1:0] top2_q;
    logic [WIDTH-1:0] top3_q;
    logic [WIDTH-1:0] top1_d;
    logic [WIDTH-1:0] top2_d;
    logic [WIDTH-1:0] top3_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dropped_q;
    logic             dropped_d;
    logic             busy_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] mrg1_c;
    logic [WIDTH-1:0] mrg2_c;
    logic [WIDTH-1:0] mrg3_c;

    // Merge the incoming triple into the running top-3.
    top3_merge #(
        .WIDTH (WIDTH)
    ) u_merge (
        .a_hi   (top1_q),
        .a_mid  (top2_q),
        .a_lo   (top3_q),
        .b_hi   (bus.in_hi),
        .b_mid  (bus.in_mid),
        .b_lo   (bus.in_lo),
        .top1_c (mrg1_c),
        .top2_c (mrg2_c),
        .top3_c (mrg3_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        top1_d    = top1_q;
        top2_d    = top2_q;
        top3_d    = top3_q;
        cnt_d     = cnt_q;
        dropped_d = dropped_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dropped_d = 1'b1;
                end
                // start clears everything, including a drop in the same cycle
                if (bus.start) begin
                    state_d   = ACCUM;
                    top1_d    = '0;
                    top2_d    = '0;
                    top3_d    = '0;
                    cnt_d     = '0;
                    dropped_d = 1'b0;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    top1_d = mrg1_c;
                    top2_d = mrg2_c;
                    top3_d = mrg3_c;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.in_valid) begin
                    dropped_d = 1'b1;
                end
                // out_valid is asserted throughout DONE
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; status flags registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            top1_q      <= '0;
            top2_q      <= '0;
            top3_q      <= '0;
            cnt_q       <= '0;
            dropped_q   <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            top1_q      <= top1_d;
            top2_q      <= top2_d;
            top3_q      <= top3_d;
            cnt_q       <= cnt_d;
            dropped_q   <= dropped_d;
            busy_q      <= (state_d == ACCUM);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign bus.top1      = top1_q;
    assign bus.top2      = top2_q;
    assign bus.top3      = top3_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.dropped   = dropped_q;

endmodule : top3_tracker

// File: tb/tb_top3_tracker.sv
// Self-checking bench for top3_tracker: directed scenarios plus randomized
// frames checked against a value-set reference model.
module tb_top3_tracker;

    localparam int W  = 3;
    localparam int FL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    top3_tracker_if #(.WIDTH(W)) bus ();

    top3_tracker #(
        .WIDTH     (W),
        .FRAME_LEN (FL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int vals[$];

    // Reference: top three of every value seen this frame plus the three
    // zeros the frame starts from, sorted descending.
    function automatic logic [3*W-1:0] model_top(input int q[$]);
        int s[$];
        s = q;
        s.push_back(0);
        s.push_back(0);
        s.push_back(0);
        s.rsort();
        return {W'(s[0]), W'(s[1]), W'(s[2])};
    endfunction

    function automatic void rand_triple(output int h, output int m, output int l);
        int s[$];
        s.push_back(int'($urandom_range(7, 0)));
        s.push_back(int'($urandom_range(7, 0)));
        s.push_back(int'($urandom_range(7, 0)));
        s.rsort();
        h = s[0];
        m = s[1];
        l = s[2];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_hi    = '0;
        bus.in_mid   = '0;
        bus.in_lo    = '0;
    endtask

    task automatic put(input int h, input int m, input int l, input bit track);
        bus.in_valid = 1'b1;
        bus.in_hi    = W'(h);
        bus.in_mid   = W'(m);
        bus.in_lo    = W'(l);
        if (track) begin
            vals.push_back(h);
            vals.push_back(m);
            vals.push_back(l);
        end
    endtask

    task automatic test_reset();
        quiet();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({bus.top1, bus.top2, bus.top3} !== '0) begin
            bad++; $display("FAIL reset_top got=%0h exp=0", {bus.top1, bus.top2, bus.top3});
        end
        total++;
        if ({bus.busy, bus.out_valid, bus.dropped} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b exp=000", {bus.busy, bus.out_valid, bus.dropped});
        end
    endtask

    task automatic test_basic();
        int tri_h[4] = '{5, 7, 6, 1};
        int tri_m[4] = '{3, 2, 6, 1};
        int tri_l[4] = '{1, 0, 4, 1};
        int busy_cycles = 0;
        logic [3*W-1:0] exp;
        vals.delete();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        if (bus.busy === 1'b1) busy_cycles++;
        total++;
        if ({bus.top1, bus.top2, bus.top3} !== '0) begin
            bad++; $display("FAIL basic_start_top got=%0h exp=0", {bus.top1, bus.top2, bus.top3});
        end
        for (int i = 0; i < 4; i++) begin
            put(tri_h[i], tri_m[i], tri_l[i], 1'b1);
            tick();
            quiet();
            if (bus.busy === 1'b1) busy_cycles++;
            exp = model_top(vals);
            total++;
            if ({bus.top1, bus.top2, bus.top3} !== exp) begin
                bad++; $display("FAIL basic_run%0d got=%0h exp=%0h", i, {bus.top1, bus.top2, bus.top3}, exp);
            end
            total++;
            if (bus.out_valid !== (i == 3)) begin
                bad++; $display("FAIL basic_valid%0d got=%b exp=%b", i, bus.out_valid, (i == 3));
            end
        end
        total++;
        if ({bus.top1, bus.top2, bus.top3} !== {3'd7, 3'd6, 3'd6}) begin
            bad++; $display("FAIL basic_final got=%0h exp=%0h", {bus.top1, bus.top2, bus.top3}, {3'd7, 3'd6, 3'd6});
        end
        total++;
        if (busy_cycles != 4) begin
            bad++; $display("FAIL basic_busy_cycles got=%0d exp=4", busy_cycles);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++;
        if ({bus.busy, bus.out_valid} !== 2'b00) begin
            bad++; $display("FAIL basic_handshake got=%b exp=00", {bus.busy, bus.out_valid});
        end
    endtask

    task automatic test_held();
        int tri_h[4] = '{5, 7, 6, 1};
        int tri_m[4] = '{3, 2, 6, 1};
        int tri_l[4] = '{1, 0, 4, 1};
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(tri_h[i], tri_m[i], tri_l[i], 1'b0);
            tick();
            quiet();
        end
        for (int c = 0; c < 10; c++) begin
            total++;
            if (bus.out_valid !== 1'b1 || {bus.top1, bus.top2, bus.top3} !== {3'd7, 3'd6, 3'd6}) begin
                bad++; $display("FAIL held_c%0d got=%b/%0h exp=1/%0h", c, bus.out_valid,
                                {bus.top1, bus.top2, bus.top3}, {3'd7, 3'd6, 3'd6});
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++;
        if ({bus.busy, bus.out_valid} !== 2'b00 || {bus.top1, bus.top2, bus.top3} !== {3'd7, 3'd6, 3'd6}) begin
            bad++; $display("FAIL held_release got=%b/%0h exp=00/%0h", {bus.busy, bus.out_valid},
                            {bus.top1, bus.top2, bus.top3}, {3'd7, 3'd6, 3'd6});
        end
    endtask

    task automatic test_gapped();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        put(7, 7, 7, 1'b0);
        tick();
        quiet();
        for (int g = 0; g < 3; g++) begin
            tick();
            total++;
            if ({bus.busy, bus.out_valid} !== 2'b10) begin
                bad++; $display("FAIL gap_idle%0d got=%b exp=10", g, {bus.busy, bus.out_valid});
            end
        end
        put(7, 7, 7, 1'b0); tick();
        put(0, 0, 0, 1'b0); tick();
        quiet();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL gap_early_done got=%b exp=0", bus.out_valid);
        end
        put(7, 0, 0, 1'b0); tick();
        quiet();
        total++;
        if (bus.out_valid !== 1'b1 || {bus.top1, bus.top2, bus.top3} !== {3'd7, 3'd7, 3'd7}) begin
            bad++; $display("FAIL gap_final got=%b/%0h exp=1/%0h", bus.out_valid,
                            {bus.top1, bus.top2, bus.top3}, {3'd7, 3'd7, 3'd7});
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_drops();
        logic [3*W-1:0] exp;
        put(5, 5, 5, 1'b0);
        tick();
        quiet();
        total++;
        if (bus.dropped !== 1'b1 || bus.busy !== 1'b0 || {bus.top1, bus.top2, bus.top3} !== {3'd7, 3'd7, 3'd7}) begin
            bad++; $display("FAIL drop_idle got=%b%b/%0h exp=10/%0h", bus.dropped, bus.busy,
                            {bus.top1, bus.top2, bus.top3}, {3'd7, 3'd7, 3'd7});
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.dropped !== 1'b0) begin
            bad++; $display("FAIL drop_clear got=%b exp=0", bus.dropped);
        end
        vals.delete();
        for (int i = 0; i < FL; i++) begin
            int h, m, l;
            rand_triple(h, m, l);
            put(h, m, l, 1'b1);
            tick();
        end
        put(7, 7, 7, 1'b0);
        tick();
        quiet();
        exp = model_top(vals);
        total++;
        if (bus.dropped !== 1'b1 || bus.out_valid !== 1'b1 || {bus.top1, bus.top2, bus.top3} !== exp) begin
            bad++; $display("FAIL drop_done got=%b%b/%0h exp=11/%0h", bus.dropped, bus.out_valid,
                            {bus.top1, bus.top2, bus.top3}, exp);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        // start together with in_valid: triple lost, flag cleared by start
        bus.start = 1'b1;
        put(3, 3, 3, 1'b0);
        tick();
        quiet();
        total++;
        if (bus.dropped !== 1'b0 || bus.busy !== 1'b1 || {bus.top1, bus.top2, bus.top3} !== '0) begin
            bad++; $display("FAIL drop_start_same got=%b%b/%0h exp=01/0", bus.dropped, bus.busy,
                            {bus.top1, bus.top2, bus.top3});
        end
        vals.delete();
        for (int i = 0; i < FL; i++) begin
            put(2, 1, 1, 1'b1);
            tick();
        end
        quiet();
        exp = model_top(vals);
        total++;
        if (bus.out_valid !== 1'b1 || {bus.top1, bus.top2, bus.top3} !== exp) begin
            bad++; $display("FAIL drop_start_frame got=%b/%0h exp=1/%0h", bus.out_valid,
                            {bus.top1, bus.top2, bus.top3}, exp);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3*W-1:0] exp;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        put(7, 7, 7, 1'b0); tick();
        put(7, 6, 5, 1'b0); tick();
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({bus.top1, bus.top2, bus.top3, bus.busy, bus.out_valid, bus.dropped} !== '0) begin
            bad++; $display("FAIL rst_mid got=%0h exp=0",
                            {bus.top1, bus.top2, bus.top3, bus.busy, bus.out_valid, bus.dropped});
        end
        vals.delete();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        put(1, 1, 0, 1'b1); tick();
        put(2, 0, 0, 1'b1); tick();
        put(1, 0, 0, 1'b1); tick();
        put(0, 0, 0, 1'b1); tick();
        quiet();
        exp = model_top(vals);
        total++;
        if (bus.out_valid !== 1'b1 || {bus.top1, bus.top2, bus.top3} !== exp) begin
            bad++; $display("FAIL rst_new_frame got=%b/%0h exp=1/%0h", bus.out_valid,
                            {bus.top1, bus.top2, bus.top3}, exp);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < FL; i++) begin
            put(6, 5, 4, 1'b0);
            tick();
        end
        quiet();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_handshake got=%b exp=0", bus.out_valid);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || {bus.top1, bus.top2, bus.top3} !== '0) begin
            bad++; $display("FAIL b2b_restart got=%b/%0h exp=1/0", bus.busy, {bus.top1, bus.top2, bus.top3});
        end
        for (int i = 0; i < FL; i++) begin
            put(2, 1, 0, 1'b0);
            tick();
        end
        quiet();
        total++;
        if (bus.out_valid !== 1'b1 || {bus.top1, bus.top2, bus.top3} !== {3'd2, 3'd2, 3'd2}) begin
            bad++; $display("FAIL b2b_final got=%b/%0h exp=1/%0h", bus.out_valid,
                            {bus.top1, bus.top2, bus.top3}, {3'd2, 3'd2, 3'd2});
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [3*W-1:0] exp;
        for (int f = 0; f < 20; f++) begin
            int cnt = 0;
            bit saw_drop = 1'b0;
            vals.delete();
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            total++;
            if (bus.busy !== 1'b1 || bus.dropped !== 1'b0) begin
                bad++; $display("FAIL rnd%0d_open got=%b%b exp=10", f, bus.busy, bus.dropped);
            end
            while (cnt < FL) begin
                if ($urandom_range(1, 0) == 1) begin
                    int h, m, l;
                    rand_triple(h, m, l);
                    put(h, m, l, 1'b1);
                    cnt++;
                end else begin
                    bus.start = 1'($urandom_range(1, 0));
                end
                tick();
                quiet();
                exp = model_top(vals);
                total++;
                if ({bus.top1, bus.top2, bus.top3} !== exp) begin
                    bad++; $display("FAIL rnd%0d_top got=%0h exp=%0h", f, {bus.top1, bus.top2, bus.top3}, exp);
                end
                total++;
                if ({bus.busy, bus.out_valid} !== ((cnt == FL) ? 2'b01 : 2'b10)) begin
                    bad++; $display("FAIL rnd%0d_flags got=%b cnt=%0d", f, {bus.busy, bus.out_valid}, cnt);
                end
            end
            for (int j = 0; j < int'($urandom_range(3, 0)); j++) begin
                if ($urandom_range(1, 0) == 1) begin
                    put(7, 7, 7, 1'b0);
                    saw_drop = 1'b1;
                end
                tick();
                quiet();
                total++;
                if (bus.out_valid !== 1'b1 || bus.dropped !== saw_drop || {bus.top1, bus.top2, bus.top3} !== exp) begin
                    bad++; $display("FAIL rnd%0d_hold got=%b%b/%0h exp=1%b/%0h", f, bus.out_valid, bus.dropped,
                                    {bus.top1, bus.top2, bus.top3}, saw_drop, exp);
                end
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            total++;
            if ({bus.busy, bus.out_valid} !== 2'b00 || {bus.top1, bus.top2, bus.top3} !== exp) begin
                bad++; $display("FAIL rnd%0d_accept got=%b/%0h exp=00/%0h", f, {bus.busy, bus.out_valid},
                                {bus.top1, bus.top2, bus.top3}, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_held();
        test_gapped();
        test_drops();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_top3_tracker

// File: doc/top3_tracker.md
# top3_tracker

Downstream consumer of the 3-input pipelined sorter. Takes one descending-sorted triple per cycle (hi ≥ mid ≥ lo) and merges it into a running top-3 register set over a frame of `FRAME_LEN` valid triples. At frame end it presents the three largest values seen, with a valid/ready handshake, to the next stage. The sorter cannot stall, so this block never back-pressures its input. Triples arriving outside a frame are dropped and flagged.

## Interface
Parameters:
- `WIDTH`, default 3: bit width of each value (unsigned).
- `FRAME_LEN`, default 4: number of valid triples per frame; must be ≥ 1.
- `CNT_W`, default `$clog2(FRAME_LEN+1)`: frame counter width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  opens a frame when idle.
- `in_valid`  in  1  `in_hi`/`in_mid`/`in_lo` carry a sorted triple this cycle.
- `in_hi`, `in_mid`, `in_lo`  in  `WIDTH`  sorted triple, `in_hi` ≥ `in_mid` ≥ `in_lo`. Ordering is guaranteed upstream and is not checked here.
- `top1`, `top2`, `top3`  out  `WIDTH`  running/final top-3, `top1` ≥ `top2` ≥ `top3`.
- `out_valid`  out  1  final frame result available.
- `out_ready`  in  1  consumer accepts the result.
- `busy`  out  1  frame in progress.
- `dropped`  out  1  sticky: a triple was discarded since the last `start`.

## Operation
- States:
  - IDLE: on `start`, go to ACCUM; clear `top*` to 0, clear the counter, clear `dropped`.
  - ACCUM: each `in_valid` merges one triple and increments the counter. The merge that brings the counter to `FRAME_LEN` moves the block to DONE.
  - DONE: `out_valid`=1 and `top*` frozen. When `out_valid && out_ready`, go to IDLE.
- Merge rule: new `{top1,top2,top3}` = the three largest of the six values {`top1`,`top2`,`top3`,`in_hi`,`in_mid`,`in_lo`}, sorted descending, with duplicates kept. Example: running (7,6,1) merged with (6,0,0) gives (7,6,6).
- Unsigned compare; no width growth. Outputs are always `WIDTH` bits.
- `in_valid` in IDLE or DONE: the triple is discarded and `dropped` is set to 1.
- `start` in ACCUM or DONE: ignored.
- `start` together with `in_valid` in IDLE: the triple is dropped and `dropped` is set. The start-clear takes priority, so `dropped` reads 0 in ACCUM.
- Reset values: state IDLE, `top1`/`top2`/`top3`=0, `out_valid`=0, `busy`=0, `dropped`=0, counter=0.
- `rst` has priority over every other input. Reset mid-frame abandons the frame with no output.

## Timing
- Merge is registered: `top*` reflects a triple one cycle after its `in_valid` edge.
- Frame completion: if the `FRAME_LEN`-th triple is sampled at edge N, then `out_valid`=1 and the final `top*` are visible after edge N (same cycle).
- `busy` = 1 exactly in ACCUM.
- `out_valid` holds, and `top*` stays stable, until the handshake completes.
- Handshake accepted at edge M: `out_valid`=0 after M. `top*` keeps its last value until the next `start`.
- Minimum frame-to-frame gap: handshake edge, then `start` in IDLE the next cycle.
- Upstream integration: `in_valid` is the sorter input-valid delayed 4 cycles, matching the sorter latency.

## Structure
- Shared package `sort_pkg`:
  - `WIDTH` default.
  - State enum `tt_state_t` {IDLE, ACCUM, DONE}.
- Sub-module `top3_merge`: combinational 3+3 sorted merge producing the top-3. Parameterised by `WIDTH`; reusable by other sort stages.
- `top3_tracker` holds the FSM, counter, registers and flags.

## Test plan
- Basic frame: `FRAME_LEN`=4, `start`, then triples (5,3,1), (7,2,0), (6,6,4), (1,1,1) on consecutive cycles → `out_valid` after the 4th edge with `top` = (7,6,6). `busy` is 1 for exactly 4 cycles.
- Held output: same frame with `out_ready`=0 for 10 cycles → `out_valid` and `top` stable throughout. `out_ready`=1 → `out_valid`=0 on the next cycle and state IDLE.
- Gapped input and ties: triples (7,7,7), idle 3 cycles, (7,7,7), (0,0,0), (7,0,0) → (7,7,7). The counter advances only on valid cycles.
- Drops: `in_valid` in IDLE with (5,5,5), then `start` → `dropped`=1, then 0 after `start`. `in_valid` in DONE → `dropped`=1 and `top` unchanged.
- Reset mid-frame: 2 triples, then `rst` for 1 cycle → all outputs 0, state IDLE. A new frame gives correct results unaffected by earlier data.
- Back-to-back frames: handshake, `start` next cycle, second frame of all (2,1,0) → (2,2,2). No carry-over from the first frame.
